// File: rtl/riscv_pkg.sv
// Shared RV32I load/store constants: funct3 codes, LSU state encoding,
// byte-strobe patterns and the alignment check used at issue time.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] lsu_state_t;
  localparam lsu_state_t S_IDLE = 2'd0;
  localparam lsu_state_t S_REQ  = 2'd1;
  localparam lsu_state_t S_RESP = 2'd2;
  localparam lsu_state_t S_ERR  = 2'd3;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B    = 4'b0001;
  localparam logic [3:0] STRB_H    = 4'b0011;
  localparam logic [3:0] STRB_W    = 4'b1111;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-addressed memory request/response bus between the LSU and memory.
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering: store data replication/strobes and
// load data extraction with sign or zero extension.
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Replicate the store operand across all lanes; the strobe picks the lane.
  always_comb begin
    wdata = 32'h0;
    wstrb = STRB_NONE;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          wdata = {4{store_data[7:0]}};
          wstrb = STRB_B << byte_off;
        end
        2'b01: begin
          wdata = {2{store_data[15:0]}};
          wstrb = STRB_H << byte_off;
        end
        default: begin
          wdata = store_data;
          wstrb = STRB_W;
        end
      endcase
    end
  end

  // Bring the addressed byte/half down to bit 0, then extend.
  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    case (funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit with misalignment trap and
// memory-response timeout.
//
// state  | meaning
// IDLE   | waiting for a start pulse with exactly one of load/store
// REQ    | mem_req held with stable address/data until mem_ready
// RESP   | one-cycle completion; load result and rd_out valid
// ERR    | one-cycle completion for misalignment or timeout
module load_store_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      is_load,
  input  logic                      is_store,
  input  logic [2:0]                funct3,
  input  logic [31:0]               addr,
  input  logic [31:0]               store_data,
  input  logic [4:0]                rd_in,
  output logic [4:0]                rd_out,
  output logic                      busy,
  output logic                      done,
  output logic                      wb_en,
  output logic                      misaligned,
  output logic                      timeout,
  output logic [31:0]               load_data,
  load_store_unit_if.master         mem
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t       state;
  logic [31:0]      addr_q;
  logic [31:0]      sdata_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_q;
  logic             store_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt;
  logic             to_q;

  logic [31:0] fmt_wdata;
  logic [3:0]  fmt_wstrb;
  logic [31:0] fmt_load;

  lsu_align u_align (
    .funct3     (f3_q),
    .byte_off   (addr_q[1:0]),
    .is_store   (store_q),
    .store_data (sdata_q),
    .rdata      (rdata_q),
    .wdata      (fmt_wdata),
    .wstrb      (fmt_wstrb),
    .load_data  (fmt_load)
  );

  // Sequencer; mem_ready is tested before the timeout so a late response still lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      addr_q  <= 32'h0;
      sdata_q <= 32'h0;
      f3_q    <= 3'b000;
      rd_q    <= 5'd0;
      store_q <= 1'b0;
      rdata_q <= 32'h0;
      cnt     <= '0;
      to_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && (is_load ^ is_store)) begin
            addr_q  <= addr;
            sdata_q <= store_data;
            f3_q    <= funct3;
            rd_q    <= rd_in;
            store_q <= is_store;
            cnt     <= '0;
            to_q    <= 1'b0;
            state   <= is_misaligned(funct3, addr[1:0]) ? S_ERR : S_REQ;
          end
        end
        S_REQ: begin
          if (mem.mem_ready) begin
            rdata_q <= mem.mem_rdata;
            state   <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            to_q  <= 1'b1;
            state <= S_ERR;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          to_q  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and bus outputs decode from state so they are zero outside their phase.
  always_comb begin
    busy           = (state != S_IDLE);
    done           = (state == S_RESP) || (state == S_ERR);
    wb_en          = (state == S_RESP) && !store_q;
    misaligned     = (state == S_ERR) && !to_q;
    timeout        = (state == S_ERR) && to_q;
    rd_out         = (state == S_RESP) ? rd_q : 5'd0;
    load_data      = ((state == S_RESP) && !store_q) ? fmt_load : 32'h0;
    mem.mem_req    = (state == S_REQ);
    mem.mem_we     = (state == S_REQ) && store_q;
    mem.mem_addr   = (state == S_REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
    mem.mem_wdata  = (state == S_REQ) ? fmt_wdata : 32'h0;
    mem.mem_wstrb  = (state == S_REQ) ? fmt_wstrb : STRB_NONE;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum REQ-state cycles to wait for mem_ready before aborting.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: a one-cycle pulse meaning the ALU address and operands are valid.
REQ-005 The block SHALL have ports is_load and is_store, input, 1 bit each: the operation type.
REQ-006 The block SHALL have port funct3, input, 3 bits: the RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-007 The block SHALL have port addr, input, 32 bits: the effective address, i.e. the ALU result.
REQ-008 The block SHALL have port store_data, input, 32 bits: the rs2 value.
REQ-009 The block SHALL have ports rd_in, input, 5 bits, and rd_out, output, 5 bits: the destination register, captured and returned.
REQ-010 The block SHALL have port busy, output, 1 bit: stalls the PC and register file while high.
REQ-011 The block SHALL have ports done, wb_en, misaligned and timeout, output, 1 bit each: completion, write-back enable and error status.
REQ-012 The block SHALL have port load_data, output, 32 bits: the aligned and extended load result.
REQ-013 The block SHALL have memory ports mem_req (output 1), mem_we (output 1), mem_addr (output 32), mem_wdata (output 32), mem_wstrb (output 4), mem_ready (input 1) and mem_rdata (input 32).

Function
REQ-014 The FSM SHALL have the states IDLE, REQ, RESP and ERR; busy SHALL equal (state != IDLE).
REQ-015 In IDLE, start with exactly one of is_load/is_store set SHALL capture addr, store_data, funct3, rd_in and the operation type; any other start SHALL be ignored.
REQ-016 Misalignment (halfword with addr[0]=1, or word with addr[1:0]!=0) SHALL move IDLE to ERR; otherwise IDLE SHALL move to REQ.
REQ-017 In REQ, mem_req SHALL be 1, and mem_addr={addr[31:2],2'b00}, mem_we, mem_wdata and mem_wstrb SHALL be held stable until mem_ready is sampled 1.
REQ-018 Store formatting SHALL be: SB gives wdata={4{byte}} and wstrb=0001<<addr[1:0]; SH gives wdata={2{half}} and wstrb=0011<<addr[1:0]; SW gives the full word and wstrb=1111.
REQ-019 For loads, mem_wstrb SHALL be 0000 and mem_we SHALL be 0.
REQ-020 When mem_ready is 1 in REQ, the block SHALL capture mem_rdata and move to RESP; mem_req SHALL be 0 in the following cycle.
REQ-021 Load extraction SHALL shift mem_rdata right by 8*addr[1:0], then sign-extend for LB/LH or zero-extend for LBU/LHU; LW SHALL pass all 32 bits unchanged.
REQ-022 RESP SHALL last one cycle with done=1 and wb_en=is_load; load_data and rd_out SHALL be valid in that cycle; the next state SHALL be IDLE.
REQ-023 ERR SHALL last one cycle with done=1, misaligned=1 and wb_en=0, with no memory request issued; the next state SHALL be IDLE.
REQ-024 A cycle counter SHALL clear on entry to REQ; after TIMEOUT_CYCLES cycles in REQ without mem_ready, the block SHALL move to ERR with timeout=1 and misaligned=0.
REQ-025 Latency SHALL be: start at cycle 0, mem_req at cycle 1, mem_ready at cycle k≥1, done at cycle k+1; a misaligned access SHALL give done at cycle 1.
REQ-026 start SHALL be ignored while busy=1; done, misaligned, timeout and wb_en SHALL be single-cycle pulses.
REQ-027 If mem_ready and the timeout limit coincide in the same cycle, mem_ready SHALL win.

Reset
REQ-028 When reset is sampled 1, the block SHALL go to IDLE and all outputs SHALL be 0 from the next cycle, including a reset during REQ, where mem_req SHALL drop at that edge.
REQ-029 reset SHALL take priority over start and mem_ready in the same cycle.

Structure
REQ-030 The funct3 encodings, the FSM state type and the strobe constants SHALL be placed in the shared package riscv_pkg.
REQ-031 The combinational data alignment and extension SHALL be a single sub-module, lsu_align, instantiated once.

Verification
REQ-032 SW: addr=0x100, store_data=0xDEADBEEF, mem_ready at cycle 3 -> mem_addr=0x100, wstrb=1111, done at cycle 4, wb_en=0.
REQ-033 LB: addr=0x203, mem_rdata=0x80FF_1234 -> load_data=0xFFFFFF80; LBU at the same address -> 0x00000080; rd_out=rd_in.
REQ-034 SH: addr=0x102, store_data=0x0000ABCD -> mem_wdata=0xABCDABCD, wstrb=1100, mem_addr=0x100.
REQ-035 LW: addr=0x101 -> done=1 and misaligned=1 at cycle 1, with mem_req never asserted.
REQ-036 Timeout: TIMEOUT_CYCLES=4, mem_ready held 0 -> timeout=1 and done=1 after 4 REQ cycles, then busy=0.
REQ-037 Reset asserted during REQ -> mem_req=0 and busy=0 the next cycle; a new start is then accepted normally.
